// File: rtl/ctrl_transfer_seq_if.sv
// ctrl_transfer_seq_if: decode request, stack memory port and PC/CCR load bundle for the sequencer
interface ctrl_transfer_seq_if #(
  parameter int PC_W   = 32,
  parameter int WORD_W = 16,
  parameter int FLAG_W = 3,
  parameter int SP_W   = 11
);
  logic              op_valid;
  logic [2:0]        op_code;
  logic [PC_W-1:0]   target_pc;
  logic [PC_W-1:0]   int_vector;
  logic [PC_W-1:0]   return_pc;
  logic [FLAG_W-1:0] flags_in;
  logic [WORD_W-1:0] mem_rdata;
  logic              busy;
  logic              mem_we;
  logic              mem_re;
  logic [SP_W-1:0]   mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              pc_load;
  logic [PC_W-1:0]   pc_out;
  logic              flags_load;
  logic [FLAG_W-1:0] flags_out;
  logic [SP_W-1:0]   sp_out;
  logic              stack_err;
  modport master (
    output op_valid, op_code, target_pc, int_vector, return_pc, flags_in, mem_rdata,
    input  busy, mem_we, mem_re, mem_addr, mem_wdata, pc_load, pc_out,
           flags_load, flags_out, sp_out, stack_err
  );
  modport slave (
    input  op_valid, op_code, target_pc, int_vector, return_pc, flags_in, mem_rdata,
    output busy, mem_we, mem_re, mem_addr, mem_wdata, pc_load, pc_out,
           flags_load, flags_out, sp_out, stack_err
  );
endinterface

// File: rtl/ctrl_transfer_seq.sv
// ctrl_transfer_seq: CALL/RET/INT/RTI stack sequencer owning SP; CTS_STACK_CHECK_EN enables stack bound aborts
module ctrl_transfer_seq #(
  parameter int PC_W     = 32,
  parameter int WORD_W   = 16,
  parameter int FLAG_W   = 3,
  parameter int SP_W     = 11,
  parameter int SP_RESET = 2**SP_W - 1
) (
  input logic clk,
  input logic reset,
  ctrl_transfer_seq_if.slave bus
);
  localparam int NW = PC_W / WORD_W;
  localparam int CW = $clog2(NW + 2);
  localparam logic [2:0] OP_CALL = 3'd1;
  localparam logic [2:0] OP_RET  = 3'd2;
  localparam logic [2:0] OP_INT  = 3'd3;
  localparam logic [2:0] OP_RTI  = 3'd4;
  localparam logic [SP_W-1:0] SP_TOP = SP_W'(SP_RESET);
  typedef enum logic [2:0] {S_IDLE, S_PUSH, S_POP, S_DRAIN, S_LOAD} state_t;
  state_t            r_state, w_next;
  logic [2:0]        r_op;
  logic [CW-1:0]     r_cnt;
  logic [SP_W-1:0]   r_sp;
  logic [PC_W-1:0]   r_sh;
  logic [PC_W-1:0]   r_pc;
  logic [FLAG_W-1:0] r_flags;
  logic [FLAG_W-1:0] r_flags_out;
  logic              r_cap_vld;
  logic              r_cap_flag;
  logic              w_accept;
  logic              w_ext;
  logic              w_last;
  logic              w_err;
  logic              w_we;
  logic              w_re;
  logic [SP_W-1:0]   w_sp_inc;
  assign w_sp_inc = r_sp + SP_W'(1);
  assign w_accept = r_state == S_IDLE && bus.op_valid && bus.op_code >= OP_CALL && bus.op_code <= OP_RTI;
  assign w_ext    = r_op == OP_INT || r_op == OP_RTI;
  assign w_last   = r_cnt == (w_ext ? CW'(NW) : CW'(NW - 1));
`ifdef CTS_STACK_CHECK_EN
  assign w_err = (r_state == S_PUSH && r_sp == '0) || (r_state == S_POP && r_sp == SP_TOP);
`else
  assign w_err = 1'b0;
`endif
  // strobes drop as soon as reset is seen so an aborted sequence writes nothing more
  assign w_we = r_state == S_PUSH && !w_err && !reset;
  assign w_re = r_state == S_POP && !w_err && !reset;
  // state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  // next state and port outputs; a bound violation returns straight to IDLE
  always_comb begin
    w_next         = r_state;
    bus.busy       = r_state != S_IDLE;
    bus.mem_we     = w_we;
    bus.mem_re     = w_re;
    bus.mem_addr   = r_state == S_POP ? w_sp_inc : r_sp;
    bus.mem_wdata  = w_we ? (r_cnt == CW'(NW) ? WORD_W'(r_flags) : r_sh[PC_W-1 -: WORD_W]) : '0;
    bus.pc_load    = r_state == S_LOAD && !reset;
    bus.flags_load = r_state == S_LOAD && !reset && r_op == OP_RTI;
    bus.pc_out     = r_pc;
    bus.flags_out  = r_flags_out;
    bus.sp_out     = r_sp;
    bus.stack_err  = w_err;
    if (r_state == S_IDLE && w_accept)
      w_next = (bus.op_code == OP_CALL || bus.op_code == OP_INT) ? S_PUSH : S_POP;
    else if (r_state == S_PUSH || r_state == S_POP)
      w_next = w_err ? S_IDLE : !w_last ? r_state : r_state == S_PUSH ? S_LOAD : S_DRAIN;
    else if (r_state == S_DRAIN)
      w_next = S_LOAD;
    else if (r_state == S_LOAD)
      w_next = S_IDLE;
  end
  // operand latch, SP update and pop-data assembly (words arrive low first, shifted in from the top)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sp        <= SP_TOP;
      r_op        <= '0;
      r_cnt       <= '0;
      r_sh        <= '0;
      r_pc        <= '0;
      r_flags     <= '0;
      r_flags_out <= '0;
      r_cap_vld   <= 1'b0;
      r_cap_flag  <= 1'b0;
    end else begin
      r_cap_vld  <= w_re;
      r_cap_flag <= r_op == OP_RTI && r_cnt == '0;
      if (w_accept) begin
        r_op    <= bus.op_code;
        r_cnt   <= '0;
        r_sh    <= bus.return_pc;
        r_flags <= bus.flags_in;
        r_pc    <= bus.op_code == OP_CALL ? bus.target_pc : bus.op_code == OP_INT ? bus.int_vector : r_pc;
      end
      if (w_we) begin
        r_sp  <= r_sp - SP_W'(1);
        r_cnt <= r_cnt + CW'(1);
        r_sh  <= r_sh << WORD_W;
      end
      if (w_re) begin
        r_sp  <= w_sp_inc;
        r_cnt <= r_cnt + CW'(1);
      end
      if (r_cap_vld && r_cap_flag) r_flags_out <= bus.mem_rdata[FLAG_W-1:0];
      if (r_cap_vld && !r_cap_flag) r_pc <= PC_W'({bus.mem_rdata, r_pc} >> WORD_W);
    end
  end
endmodule

// File: tb/tb_ctrl_transfer_seq.sv
// tb_ctrl_transfer_seq: randomized CALL/RET/INT/RTI traffic against a stack-level reference model
module tb_ctrl_transfer_seq;
  localparam int PC_W = 32, WORD_W = 16, FLAG_W = 3, SP_W = 11;
  localparam int NW = PC_W / WORD_W, DEPTH = 2**SP_W;
  localparam logic [SP_W-1:0] SPR = SP_W'(DEPTH - 1);
`ifdef CTS_STACK_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic do_init = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] mm [DEPTH];
  logic [SP_W-1:0] msp;
  ctrl_transfer_seq_if #(.PC_W(PC_W), .WORD_W(WORD_W), .FLAG_W(FLAG_W), .SP_W(SP_W)) bus ();
  ctrl_transfer_seq #(.PC_W(PC_W), .WORD_W(WORD_W), .FLAG_W(FLAG_W), .SP_W(SP_W)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  // data memory with one-cycle read latency
  always @(posedge clk) begin
    if (do_init) for (int i = 0; i < DEPTH; i++) mem[i] <= WORD_W'(i * 37 + 5);
    else begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
    end
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic run_op(input logic [2:0] code, input logic [PC_W-1:0] ret, input logic [PC_W-1:0] tgt,
                        input logic [PC_W-1:0] vec, input logic [FLAG_W-1:0] flg);
    logic [WORD_W-1:0] wl[$];
    logic [WORD_W-1:0] rd[$];
    logic [63:0] ew[$];
    logic [63:0] ow[$];
    logic [SP_W-1:0] er[$];
    logic [SP_W-1:0] orr[$];
    logic [PC_W-1:0] epc, opc;
    logic [FLAG_W-1:0] eflg, oflg;
    int err_at, n, lat_load, lat_end, c_load, c_err, c_end, n_load, n_errp, ofl;
    bit is_push, is_pop;
    err_at = -1; n = 0; epc = '0; eflg = '0; opc = '0; oflg = '0;
    c_load = 0; c_err = 0; c_end = 0; n_load = 0; n_errp = 0; ofl = 0;
    is_push = code == 3'd1 || code == 3'd3;
    is_pop  = code == 3'd2 || code == 3'd4;
    if (is_push) begin
      for (int k = NW - 1; k >= 0; k--) wl.push_back(ret[k*WORD_W +: WORD_W]);
      if (code == 3'd3) wl.push_back(WORD_W'(flg));
      foreach (wl[i]) if (err_at < 0) begin
        if (CHK && msp == '0) err_at = i;
        else begin
          ew.push_back(64'({msp, wl[i]}));
          mm[msp] = wl[i];
          msp--;
        end
      end
      n = wl.size();
      epc = code == 3'd1 ? tgt : vec;
    end else if (is_pop) begin
      n = code == 3'd4 ? NW + 1 : NW;
      for (int i = 0; i < n; i++) if (err_at < 0) begin
        if (CHK && msp == SPR) err_at = i;
        else begin
          msp++;
          er.push_back(msp);
          rd.push_back(mm[msp]);
        end
      end
      if (err_at < 0) begin
        if (code == 3'd4) eflg = rd[0][FLAG_W-1:0];
        for (int k = 0; k < NW; k++) epc[k*WORD_W +: WORD_W] = rd[k + (code == 3'd4 ? 1 : 0)];
      end
    end
    if (!(is_push || is_pop)) begin lat_load = 0; lat_end = 1; end
    else if (err_at >= 0) begin lat_load = 0; lat_end = err_at + 2; end
    else begin lat_load = is_push ? n + 1 : n + 2; lat_end = lat_load + 1; end
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op_code = code; bus.return_pc = ret;
    bus.target_pc = tgt; bus.int_vector = vec; bus.flags_in = flg;
    check("accept_busy", 64'(bus.busy), 64'(0));
    for (int c = 1; c <= 20 && c_end == 0; c++) begin
      @(negedge clk);
      check("we_re_excl", 64'(bus.mem_we & bus.mem_re), 64'(0));
      if (bus.mem_we) ow.push_back(64'({bus.mem_addr, bus.mem_wdata}));
      if (bus.mem_re) orr.push_back(bus.mem_addr);
      if (bus.pc_load) begin
        n_load++; c_load = c; opc = bus.pc_out; ofl = int'(bus.flags_load); oflg = bus.flags_out;
      end
      if (bus.stack_err) begin n_errp++; c_err = c; end
      if (!bus.busy) begin
        c_end = c;
        bus.op_valid = 1'b0;
      end else begin
        bus.op_valid = 1'($urandom); bus.op_code = 3'($urandom); bus.return_pc = $urandom;
        bus.target_pc = $urandom; bus.int_vector = $urandom; bus.flags_in = 3'($urandom);
      end
    end
    check("end_cycle", 64'(c_end), 64'(lat_end));
    check("n_pc_load", 64'(n_load), 64'(lat_load > 0 ? 1 : 0));
    if (lat_load > 0) begin
      check("load_cycle", 64'(c_load), 64'(lat_load));
      check("pc_out", 64'(opc), 64'(epc));
      check("flags_load", 64'(ofl), 64'(code == 3'd4 ? 1 : 0));
      if (code == 3'd4) check("flags_out", 64'(oflg), 64'(eflg));
    end
    check("n_stack_err", 64'(n_errp), 64'(err_at >= 0 ? 1 : 0));
    if (err_at >= 0) check("err_cycle", 64'(c_err), 64'(err_at + 1));
    check("n_writes", 64'(ow.size()), 64'(ew.size()));
    foreach (ew[i]) if (i < ow.size()) check("write", ow[i], ew[i]);
    check("n_reads", 64'(orr.size()), 64'(er.size()));
    foreach (er[i]) if (i < orr.size()) check("read_addr", 64'(orr[i]), 64'(er[i]));
    check("sp_out", 64'(bus.sp_out), 64'(msp));
  endtask
  initial begin
    logic [PC_W-1:0] r;
    bus.op_valid = 1'b0; bus.op_code = '0; bus.target_pc = '0;
    bus.int_vector = '0; bus.return_pc = '0; bus.flags_in = '0;
    for (int i = 0; i < DEPTH; i++) mm[i] = WORD_W'(i * 37 + 5);
    msp = SPR;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    do_init = 1'b0;
    check("rst_sp", 64'(bus.sp_out), 64'(2047));
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_pc_load", 64'(bus.pc_load), 64'(0));
    check("rst_stack_err", 64'(bus.stack_err), 64'(0));
    run_op(3'd1, 32'h0001_0024, 32'h0000_0100, 32'h0, 3'd0);
    run_op(3'd2, 32'h0, 32'h0, 32'h0, 3'd0);
    run_op(3'd3, 32'h0001_0024, 32'h0, 32'h0000_0020, 3'b101);
    run_op(3'd4, 32'h0, 32'h0, 32'h0, 3'd0);
    run_op(3'd2, 32'h0, 32'h0, 32'h0, 3'd0);
    r = 32'h0001_0024;
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op_code = 3'd1; bus.return_pc = r; bus.target_pc = 32'h0000_0100;
    @(negedge clk);
    bus.op_valid = 1'b0;
    check("abort_w1_we", 64'(bus.mem_we), 64'(1));
    check("abort_w1_addr", 64'(bus.mem_addr), 64'(msp));
    mm[msp] = r[PC_W-1 -: WORD_W];
    @(negedge clk);
    reset = 1'b1;
    #1 check("abort_we_gated", 64'(bus.mem_we), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    msp = SPR;
    check("abort_busy", 64'(bus.busy), 64'(0));
    check("abort_sp", 64'(bus.sp_out), 64'(2047));
    check("abort_pc_load", 64'(bus.pc_load), 64'(0));
    repeat (300) run_op(3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, 3'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ctrl_transfer_seq.md
# ctrl_transfer_seq

Parametrised control-transfer sequencer for the five-stage pipeline. It replaces the fixed call-state-machine and ad-hoc PC/CCR pop logic with one block that owns the stack pointer and performs CALL, RET, INT and RTI as multi-cycle stack sequences. The PC and flag widths are generic over the data-memory word width. It sits beside decode: it stalls fetch/decode while busy and drives the data-memory port and the PC/CCR load paths.

## Interface
- PC_W, 32: program-counter width; must be an integer multiple of WORD_W.
- WORD_W, 16: data-memory word width.
- FLAG_W, 3: CCR width; must be ≤ WORD_W.
- SP_W, 11: stack-pointer / memory address width.
- SP_RESET, 2**SP_W-1: stack-pointer reset value (stack top; grows down).

- clk  in  1  rising-edge clock.
- reset  in  1  one clock; reset is synchronous and active-high.
- op_valid  in  1  request from decode; sampled only in IDLE.
- op_code  in  3  0 NONE, 1 CALL, 2 RET, 3 INT, 4 RTI; 5–7 treated as NONE.
- target_pc  in  PC_W  CALL destination.
- int_vector  in  PC_W  INT destination.
- return_pc  in  PC_W  PC to save (CALL/INT).
- flags_in  in  FLAG_W  CCR to save (INT).
- mem_rdata  in  WORD_W  read data, valid the cycle after mem_re.
- busy  out  1  state ≠ IDLE; stalls fetch/decode.
- mem_we  out  1  stack write strobe.
- mem_re  out  1  stack read strobe.
- mem_addr  out  SP_W  stack address.
- mem_wdata  out  WORD_W  stack write data.
- pc_load  out  1  one-cycle PC load pulse.
- pc_out  out  PC_W  PC value, valid with pc_load.
- flags_load  out  1  one-cycle CCR restore pulse (RTI only).
- flags_out  out  FLAG_W  restored CCR.
- sp_out  out  SP_W  current stack pointer.
- stack_err  out  1  one-cycle stack over/underflow pulse (see Configuration).

## Operation
- NW = PC_W/WORD_W. PC word k = pc[k*WORD_W +: WORD_W].
- Push: write mem[SP] and set SP ← SP−1. Pop: set SP ← SP+1, then read mem[new SP]. All SP arithmetic is modulo 2**SP_W.
- CALL: push return_pc words NW−1 down to 0, then LOAD with pc_out = target_pc latched at accept.
- INT: push PC words as for CALL, then push flags zero-extended to WORD_W, then LOAD with int_vector.
- RET: pop words 0 up to NW−1, assemble them into pc_out, then LOAD.
- RTI: pop the flags word (low FLAG_W bits go to flags_out), then pop PC words as for RET, then LOAD with pc_load and flags_load together.
- All inputs (return_pc, flags_in, target_pc, int_vector) are latched in the accept cycle.
- States:
  - IDLE → PUSH (CALL/INT) or POP (RET/RTI) on op_valid with a valid op.
  - PUSH: one word per cycle; → LOAD after the last word.
  - POP: one mem_re per cycle, back-to-back; → DRAIN after the last read.
  - DRAIN: captures the final mem_rdata; → LOAD.
  - LOAD: asserts pc_load (plus flags_load for RTI); → IDLE.
- op_valid while busy is ignored. The NONE code is ignored.
- Reset values: state IDLE, SP = SP_RESET, all strobes 0, pc_out/flags_out 0.
- reset mid-sequence aborts immediately. Words already pushed are not undone, and SP returns to SP_RESET.

## Timing
- Accept in cycle 0, with busy still 0 in that cycle. busy is 1 from cycle 1 until the LOAD cycle inclusive.
- CALL latency: NW push cycles + 1 LOAD cycle. INT latency: NW+1 push cycles + 1 LOAD cycle.
- RET latency: NW reads + DRAIN + LOAD = NW+2 cycles. RTI latency: NW+3 cycles.
- Each mem_rdata word is captured in the cycle after its mem_re.
- mem_we and mem_re are never high together. The memory port is idle in IDLE, DRAIN and LOAD.

## Configuration
- CTS_STACK_CHECK_EN defined:
  - A push with SP == 0, or a pop with SP == SP_RESET, aborts the operation.
  - stack_err pulses for one cycle, no memory access occurs, SP is unchanged, no pc_load is issued, and the block returns to IDLE.
  - The check applies per word, so an op can abort partway through a sequence.
- CTS_STACK_CHECK_EN undefined: stack_err is tied 0 and SP wraps silently.

## Test plan
- Reset: assert reset for 2 cycles → sp_out = 2047, busy = 0, pc_load = 0, stack_err = 0.
- CALL with return_pc 0x0001_0024, target 0x0000_0100 → writes 0x0001@2047 and 0x0024@2046. LOAD in cycle 3 with pc_out = 0x100. sp_out = 2045, busy = 0 in cycle 4.
- RET following that CALL → mem_re @2046 then @2047. pc_load in cycle 4 with pc_out = 0x0001_0024. sp_out = 2047.
- INT with flags 3'b101, vector 0x20, return_pc 0x0001_0024 → writes 0x0001, 0x0024, 0x0005 at 2047..2045, then pc_out = 0x20. A following RTI → flags_load with flags_out = 3'b101 together with pc_load, pc_out = 0x0001_0024, sp_out = 2047.
- RET on empty stack:
  - With CTS_STACK_CHECK_EN → stack_err pulse, no mem_re, sp_out stays 2047, no pc_load.
  - Without it → reads @0 then @1, sp_out = 1.
- reset asserted during the second PUSH cycle of a CALL → next cycle state IDLE, sp_out = 2047, no pc_load. Also: op_valid=1 with RET while busy → ignored, no extra mem_re.
